alu_md: RTL and testbench
=========================

ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 The block SHALL have parameter N, default 32, datapath width, legal values: power of two, 8..64.
REQ-002 The block SHALL have port clk, input, 1 bit: sole clock, all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands and op valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block accepts a new operation.
REQ-006 The block SHALL have ports src1 and src2, inputs, N bits each: operands.
REQ-007 The block SHALL have port op, input, 5 bits: operation select.
REQ-008 The block SHALL have port out_valid, output, 1 bit: res/flags hold a completed result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-010 The block SHALL have port res, output, N bits: registered result.
REQ-011 The block SHALL have port flags, output, 4 bits: registered {V,C,N,Z} on bits [3:0] = {3,2,1,0}.
REQ-012 The block SHALL have port busy, output, 1 bit: high in CALC state.

Function
REQ-013 The block SHALL implement op 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 SLT (signed), 00110 SRA (arithmetic), 00111 SRL, 01000 SLL, and 01001 SLTU; every other 0xxxx code SHALL execute ADD.
REQ-014 The block SHALL implement op 10000 MUL (low N), 10001 MULH (s*s high N), 10010 MULHSU (s*u high N), 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, and 10111 REMU; codes 11xxx SHALL execute ADD.
REQ-015 The block SHALL take shift amounts from src2[log2(N)-1:0] only.
REQ-016 The block SHALL have states IDLE, CALC, and DONE, with in_ready = (state==IDLE), out_valid = (state==DONE), and busy = (state==CALC).
REQ-017 The block SHALL accept an operation on a rising edge where in_valid && in_ready, capturing src1, src2, and op; inputs outside acceptance SHALL be ignored.
REQ-018 A base op (0xxxx or 11xxx) SHALL go IDLE->DONE on the accepting edge, so out_valid is high in the next cycle (latency 1).
REQ-019 A mul/div op (10xxx) SHALL go IDLE->CALC, run exactly N iterations (radix-2 shift-add multiply, restoring divide) counted by an internal down-counter, then go CALC->DONE, so out_valid is high N+1 cycles after acceptance.
REQ-020 In DONE, res and flags SHALL hold stable until out_ready is high on an edge, after which the state SHALL return to IDLE; a new operation SHALL NOT be accepted in the same cycle.
REQ-021 In_valid and out_ready SHALL be ignored in CALC; an operation SHALL NOT be aborted except by reset.
REQ-022 Base-op flags SHALL be: Z = (res==0); N = res[N-1]; C = carry out of ADD, or no-borrow (src1 >= src2 unsigned) for SUB, 0 otherwise; V = signed overflow for ADD/SUB, 0 otherwise.
REQ-023 Mul/div flags SHALL be: Z and N from res; C=0; V=0.
REQ-024 Divide by zero SHALL produce DIV/DIVU quotient all-ones and REM/REMU remainder = src1, with no exception.
REQ-025 Signed overflow (src1 = most-negative, src2 = -1) SHALL produce DIV = most-negative and REM = 0.
REQ-026 Signed division SHALL truncate toward zero, and the remainder sign SHALL follow the dividend.

Reset
REQ-027 When rst_n is low on an edge, the block SHALL force state IDLE, counter 0, res 0, and flags 0, giving out_valid=0, busy=0, and in_ready=1 in the next cycle.
REQ-028 Reset asserted during CALC or DONE SHALL discard the operation, and no out_valid pulse SHALL follow.
REQ-029 An in_valid sampled on an edge with rst_n low SHALL NOT be accepted.

Verification
REQ-030 The bench SHALL cover, with N=32: ADD 0xFFFFFFFF+1 -> res 0, Z=1, C=1, V=0, out_valid 1 cycle after acceptance.
REQ-031 The bench SHALL cover: SUB 0x80000000-1 -> res 0x7FFFFFFF, V=1, C=1; SRA 0x80000000 by src2=0x24 -> res 0xF8000000 (shift 4).
REQ-032 The bench SHALL cover: MULH 0xFFFFFFFF*0xFFFFFFFF -> res 0, and MULHU with the same operands -> 0xFFFFFFFE; out_valid exactly 33 cycles after acceptance, busy high 32 cycles.
REQ-033 The bench SHALL cover: DIV -7/2 -> -3; REM -7/2 -> -1; DIVU x/0 -> 0xFFFFFFFF; REM 0x80000000/-1 -> 0.
REQ-034 The bench SHALL cover: out_ready held low for 5 cycles in DONE -> res, flags, and out_valid stable, in_ready low throughout.
REQ-035 The bench SHALL cover: rst_n low at CALC cycle 10 -> next cycle state IDLE, out_valid 0, res 0, and no result emerges afterwards.

Source files
------------

// File: rtl/alu_md.sv
// ALU with iterative multiply/divide behind a valid/ready handshake.
// Ports: clk, rst_n, in_valid/in_ready, src1, src2, op, out_valid/out_ready, res, flags {V,C,N,Z}, busy.
module alu_md #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] src1,
  input  logic [N-1:0] src2,
  input  logic [4:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] res,
  output logic [3:0]   flags,
  output logic         busy
);

  localparam int LW = $clog2(N);
  localparam int CW = LW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_res;
  logic [3:0]    r_flags;
  logic [2:0]    r_mop;
  logic          r_negq;
  logic          r_negr;
  logic [N-1:0]  r_hi;
  logic [N-1:0]  r_lo;
  logic [N-1:0]  r_d;

  logic          w_is_md;
  logic [LW-1:0] w_shamt;
  logic [N:0]    w_sum;
  logic [N:0]    w_dif;
  logic [N-1:0]  w_sra;
  logic [N-1:0]  w_bres;
  logic          w_bc;
  logic          w_bv;

  assign w_is_md = (op[4:3] == 2'b10);
  assign w_shamt = src2[LW-1:0];
  assign w_sum   = {1'b0, src1} + {1'b0, src2};
  assign w_dif   = {1'b0, src1} - {1'b0, src2};
  assign w_sra   = $signed(src1) >>> w_shamt;

  always_comb begin
    w_bres = w_sum[N-1:0];
    w_bc   = 1'b0;
    w_bv   = 1'b0;
    case (op)
      5'b00001: begin
        w_bres = w_dif[N-1:0];
        w_bc   = ~w_dif[N];
        w_bv   = (src1[N-1] != src2[N-1]) &&
                 (w_dif[N-1] != src1[N-1]);
      end
      5'b00010: w_bres = src1 & src2;
      5'b00011: w_bres = src1 | src2;
      5'b00100: w_bres = src1 ^ src2;
      5'b00101: w_bres = {{(N-1){1'b0}},
                          $signed(src1) < $signed(src2)};
      5'b00110: w_bres = w_sra;
      5'b00111: w_bres = src1 >> w_shamt;
      5'b01000: w_bres = src1 << w_shamt;
      5'b01001: w_bres = {{(N-1){1'b0}}, src1 < src2};
      default: begin
        w_bc = w_sum[N];
        w_bv = (src1[N-1] == src2[N-1]) &&
               (w_sum[N-1] != src1[N-1]);
      end
    endcase
  end

  // Mul/div run on magnitudes; signs are re-applied at the end.
  logic         w_sa;
  logic         w_sb;
  logic         w_an;
  logic         w_bn;
  logic         w_bz;
  logic [N-1:0] w_am;
  logic [N-1:0] w_bm;
  logic         w_negq;

  assign w_sa = (op[2:0] == 3'b001) || (op[2:0] == 3'b010) ||
                (op[2:0] == 3'b100) || (op[2:0] == 3'b110);
  assign w_sb = (op[2:0] == 3'b001) ||
                (op[2:0] == 3'b100) || (op[2:0] == 3'b110);
  assign w_an = w_sa & src1[N-1];
  assign w_bn = w_sb & src2[N-1];
  assign w_bz = (src2 == '0);
  assign w_am = w_an ? -src1 : src1;
  assign w_bm = w_bn ? -src2 : src2;
  // Divide by zero keeps an all-ones quotient regardless of sign.
  assign w_negq = op[2] ? ((w_an ^ w_bn) & ~w_bz) : (w_an ^ w_bn);

  logic [N:0]     w_madd;
  logic [N:0]     w_rsh;
  logic [N+1:0]   w_rdf;
  logic           w_ok;
  logic [N-1:0]   w_hi_nx;
  logic [N-1:0]   w_lo_nx;
  logic [2*N-1:0] w_prod;
  logic [2*N-1:0] w_prods;
  logic [N-1:0]   w_q;
  logic [N-1:0]   w_r;
  logic [N-1:0]   w_mres;

  assign w_madd = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_d : '0)};
  assign w_rsh  = {r_hi, r_lo[N-1]};
  assign w_rdf  = {1'b0, w_rsh} - {2'b00, r_d};
  assign w_ok   = ~w_rdf[N+1];

  always_comb begin
    w_hi_nx = w_madd[N:1];
    w_lo_nx = {w_madd[0], r_lo[N-1:1]};
    if (r_mop[2]) begin
      w_hi_nx = w_ok ? w_rdf[N-1:0] : w_rsh[N-1:0];
      w_lo_nx = {r_lo[N-2:0], w_ok};
    end
  end

  assign w_prod  = {w_hi_nx, w_lo_nx};
  assign w_prods = r_negq ? -w_prod : w_prod;
  assign w_q     = r_negq ? -w_lo_nx : w_lo_nx;
  assign w_r     = r_negr ? -w_hi_nx : w_hi_nx;

  always_comb begin
    w_mres = w_r;
    case (r_mop)
      3'b000:                 w_mres = w_prods[N-1:0];
      3'b001, 3'b010, 3'b011: w_mres = w_prods[2*N-1:N];
      3'b100, 3'b101:         w_mres = w_q;
      default:                w_mres = w_r;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:
        if (in_valid)
          w_state_nx = w_is_md ? S_CALC : S_DONE;
      S_CALC:
        if (r_cnt == CW'(1))
          w_state_nx = S_DONE;
      S_DONE:
        if (out_ready)
          w_state_nx = S_IDLE;
      default:
        w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_res   <= '0;
      r_flags <= '0;
      r_mop   <= '0;
      r_negq  <= 1'b0;
      r_negr  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_d     <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (in_valid) begin
            if (w_is_md) begin
              r_mop  <= op[2:0];
              r_negq <= w_negq;
              r_negr <= w_an;
              r_hi   <= '0;
              r_lo   <= w_am;
              r_d    <= w_bm;
              r_cnt  <= CW'(N);
            end else begin
              r_res   <= w_bres;
              r_flags <= {w_bv, w_bc, w_bres[N-1],
                          w_bres == '0};
            end
          end
        S_CALC: begin
          r_hi  <= w_hi_nx;
          r_lo  <= w_lo_nx;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_res   <= w_mres;
            r_flags <= {2'b00, w_mres[N-1], w_mres == '0};
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_CALC);
  assign out_valid = (r_state == S_DONE);
  assign res       = r_res;
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu_md.sv
// Randomised bench for alu_md against a plain-arithmetic model.
// Checks results every DONE cycle plus latency, handshake and reset.
module tb_alu_md;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [4:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] res;
  logic [3:0]  flags;
  logic        busy;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;
  logic [35:0] q[$];

  alu_md #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [35:0] model(input logic [4:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, s;
    longint unsigned ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    logic v, c;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sh = int'(b % 32);
    v = 1'b0;
    c = 1'b0;
    p = ua + ub;
    r = p[31:0];
    if (o[4:3] == 2'b10) begin
      case (o[2:0])
        3'd0: begin p = ua * ub; r = p[31:0]; end
        3'd1: begin p = sa * sb; r = p[63:32]; end
        3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
        3'd3: begin p = ua * ub; r = p[63:32]; end
        3'd4: begin
          if (b == 0) r = 32'hFFFF_FFFF;
          else begin p = sa / sb; r = p[31:0]; end
        end
        3'd5: begin
          if (b == 0) r = 32'hFFFF_FFFF;
          else begin p = ua / ub; r = p[31:0]; end
        end
        3'd6: begin
          if (b == 0) r = a;
          else begin p = sa % sb; r = p[31:0]; end
        end
        default: begin
          if (b == 0) r = a;
          else begin p = ua % ub; r = p[31:0]; end
        end
      endcase
    end else if (o == 5'd1) begin
      r = a - b;
      c = (ua >= ub);
      s = sa - sb;
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (o == 5'd2) r = a & b;
    else if (o == 5'd3) r = a | b;
    else if (o == 5'd4) r = a ^ b;
    else if (o == 5'd5) r = (sa < sb) ? 32'd1 : 32'd0;
    else if (o == 5'd6) r = $signed(a) >>> sh;
    else if (o == 5'd7) r = a >> sh;
    else if (o == 5'd8) r = a << sh;
    else if (o == 5'd9) r = (ua < ub) ? 32'd1 : 32'd0;
    else begin
      c = p[32];
      s = sa + sb;
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    return {v, c, r[31], r == 32'd0, r};
  endfunction

  // Compare process: every meaningful cycle against the model queue.
  always @(negedge clk) begin
    if (rst_n && started) begin
      chk("onehot_state", 64'($countones({in_ready, busy, out_valid})),
          64'd1);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          chk("result", {28'd0, flags, res}, {28'd0, q[0]});
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int lat, bc, w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk("ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = o; src1 = a; src2 = b;
    q.push_back(model(o, a, b));
    @(posedge clk); #1;
    lat = 1; bc = 0;
    while (!out_valid && lat < 60) begin
      if (busy) bc++;
      in_valid = 1'($urandom); src1 = $urandom;
      src2 = $urandom; op = 5'($urandom);
      @(posedge clk); #1; lat++;
    end
    chk("latency", 64'(lat), (o[4:3] == 2'b10) ? 64'd33 : 64'd1);
    if (o[4:3] == 2'b10) chk("busy_cycles", 64'(bc), 64'd32);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom); src1 = $urandom; op = 5'($urandom);
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk("hold_state", {62'd0, out_valid, in_ready}, 64'd2);
    end
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk("release_state", {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with in_valid asserted: nothing may be accepted.
    in_valid = 1'b1; op = 5'h10; src1 = 32'h1234; src2 = 32'h5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {61'd0, in_ready, busy, out_valid}, 64'd4);
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    in_valid = 1'b0; rst_n = 1'b1; started = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", 64'(in_ready), 64'd1);

    // Hand-computed pins of the model.
    chk("m_add", 64'(model(5'h00, 32'hFFFF_FFFF, 32'd1)),
        64'h5_0000_0000);
    chk("m_sub", 64'(model(5'h01, 32'h8000_0000, 32'd1)),
        64'hC_7FFF_FFFF);
    chk("m_sra", 64'(model(5'h06, 32'h8000_0000, 32'h24)),
        64'h2_F800_0000);
    chk("m_mulh", 64'(model(5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF)),
        64'h1_0000_0000);
    chk("m_mulhu", 64'(model(5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF)),
        64'h2_FFFF_FFFE);
    chk("m_div", 64'(model(5'h14, -32'd7, 32'd2)), 64'h2_FFFF_FFFD);
    chk("m_rem", 64'(model(5'h16, -32'd7, 32'd2)), 64'h2_FFFF_FFFF);
    chk("m_divu0", 64'(model(5'h15, 32'd99, 32'd0)), 64'h2_FFFF_FFFF);
    chk("m_remov", 64'(model(5'h16, 32'h8000_0000, 32'hFFFF_FFFF)),
        64'h1_0000_0000);

    // Directed cases through the DUT.
    run_op(5'h00, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(5'h01, 32'h8000_0000, 32'd1, 1);
    run_op(5'h06, 32'h8000_0000, 32'h24, 0);
    run_op(5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(5'h14, -32'd7, 32'd2, 0);
    run_op(5'h16, -32'd7, 32'd2, 0);
    run_op(5'h15, 32'd99, 32'd0, 0);
    run_op(5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(5'h14, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(5'h14, -32'd5, 32'd0, 0);
    run_op(5'h16, -32'd5, 32'd0, 0);
    run_op(5'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);

    // Reset in the tenth CALC cycle.
    in_valid = 1'b1; op = 5'h10; src1 = 32'd77; src2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("calc10_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("calcrst_state", {61'd0, in_ready, busy, out_valid}, 64'd4);
    chk("calcrst_res", {28'd0, flags, res}, 64'd0);
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("calcrst_no_result", 64'(seen), 64'd0);
    end

    // Randomised operations.
    repeat (150) begin
      logic [4:0] o;
      o = 5'($urandom);
      if ($urandom_range(0, 1) == 0) o = {2'b10, 3'($urandom)};
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      run_op(o, rnd_opnd(), rnd_opnd(), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
